// File: rtl/huff_bit_feeder.sv
// Byte-to-chunk bit feeder for the Huffman decoder: buffers compressed bytes in an
// MSB-aligned accumulator and emits 1..CHUNK_MAX bit chunks, flushing a short tail at end of stream.
module huff_bit_feeder #(
    parameter int unsigned CHUNK_MAX = 4,
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           cfg_chunk,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    input  logic                 byte_last,
    input  logic [2:0]           byte_last_bits,
    output logic                 byte_ready,
    output logic                 svalid,
    output logic [CHUNK_MAX-1:0] in_bits,
    output logic [2:0]           in_len,
    input  logic                 aready,
    output logic                 stream_done,
    output logic [CNT_W-1:0]     bits_sent
);

    localparam int unsigned AC_W  = $clog2(ACC_W + 1);
    localparam int unsigned PAD_W = ACC_W - 8;

    typedef enum logic {RUN, FLUSH} state_e;

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [AC_W-1:0]      acc_cnt_q, acc_cnt_d;
    logic                 svalid_q, svalid_d;
    logic [CHUNK_MAX-1:0] in_bits_q, in_bits_d;
    logic [2:0]           in_len_q, in_len_d;
    logic                 stream_done_q, stream_done_d;
    logic [CNT_W-1:0]     bits_sent_q, bits_sent_d;

    logic [AC_W-1:0]      chunk_c;
    logic [AC_W-1:0]      take;
    logic [AC_W-1:0]      kept_cnt;
    logic [AC_W-1:0]      n_bits;
    logic [CHUNK_MAX-1:0] top;
    logic [CHUNK_MAX-1:0] chunk_bits;
    logic [ACC_W-1:0]     kept;
    logic [ACC_W-1:0]     append;
    logic [7:0]           byte_mask;
    logic                 accept;
    logic                 xfer;
    logic                 load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            acc_q         <= '0;
            acc_cnt_q     <= '0;
            svalid_q      <= 1'b0;
            in_bits_q     <= '0;
            in_len_q      <= '0;
            stream_done_q <= 1'b0;
            bits_sent_q   <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            acc_cnt_q     <= acc_cnt_d;
            svalid_q      <= svalid_d;
            in_bits_q     <= in_bits_d;
            in_len_q      <= in_len_d;
            stream_done_q <= stream_done_d;
            bits_sent_q   <= bits_sent_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        acc_cnt_d     = acc_cnt_q;
        svalid_d      = svalid_q;
        in_bits_d     = in_bits_q;
        in_len_d      = in_len_q;
        stream_done_d = 1'b0;
        bits_sent_d   = bits_sent_q;

        chunk_c = (cfg_chunk == 3'd0 || 32'(cfg_chunk) > CHUNK_MAX) ? AC_W'(CHUNK_MAX)
                                                                    : AC_W'(cfg_chunk);
        // Room for a full byte only when at most ACC_W-8 bits are buffered
        byte_ready = (state_q == RUN) && (acc_cnt_q <= AC_W'(PAD_W));
        accept     = byte_valid && byte_ready;
        xfer       = svalid_q && aready;
        load       = (!svalid_q || aready) &&
                     ((acc_cnt_q >= chunk_c) || (state_q == FLUSH && acc_cnt_q != '0));

        take       = load ? ((acc_cnt_q < chunk_c) ? acc_cnt_q : chunk_c) : '0;
        top        = acc_q[ACC_W-1 -: CHUNK_MAX];
        chunk_bits = top >> (AC_W'(CHUNK_MAX) - take);
        kept       = acc_q << take;
        kept_cnt   = acc_cnt_q - take;

        // New byte lands directly behind the bits that survive this cycle's shift
        n_bits    = (byte_last && byte_last_bits != 3'd0) ? AC_W'(byte_last_bits) : AC_W'(8);
        byte_mask = ~(8'hFF >> n_bits);
        append    = {byte_data & byte_mask, {PAD_W{1'b0}}} >> kept_cnt;

        acc_d     = accept ? (kept | append) : kept;
        acc_cnt_d = kept_cnt + (accept ? n_bits : AC_W'(0));

        if (load) begin
            svalid_d  = 1'b1;
            in_bits_d = chunk_bits;
            in_len_d  = 3'(take);
        end else if (aready) begin
            svalid_d  = 1'b0;
        end

        if (xfer) begin
            bits_sent_d = bits_sent_q + CNT_W'(in_len_q);
        end

        case (state_q)
            RUN: begin
                if (accept && byte_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (xfer && acc_cnt_q == '0) begin
                    state_d       = RUN;
                    stream_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign svalid      = svalid_q;
    assign in_bits     = in_bits_q;
    assign in_len      = in_len_q;
    assign stream_done = stream_done_q;
    assign bits_sent   = bits_sent_q;

endmodule

// File: tb/tb_huff_bit_feeder.sv
// Scoreboard bench for huff_bit_feeder: a bit-queue model predicts chunks, a negedge monitor checks them.
module tb_huff_bit_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] cfg_chunk;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic [2:0] byte_last_bits;
    logic       byte_ready;
    logic       svalid;
    logic [3:0] in_bits;
    logic [2:0] in_len;
    logic       aready;
    logic       stream_done;
    logic [15:0] bits_sent;

    huff_bit_feeder dut (
        .clk(clk), .reset(reset), .cfg_chunk(cfg_chunk),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_last_bits(byte_last_bits), .byte_ready(byte_ready),
        .svalid(svalid), .in_bits(in_bits), .in_len(in_len), .aready(aready),
        .stream_done(stream_done), .bits_sent(bits_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bits;
        int         len;
        bit         last;
    } chunk_t;

    chunk_t     exp_q[$];
    bit         mq[$];
    int         checks = 0;
    int         failures = 0;
    int         model_sent = 0;
    bit         done_next = 0;
    bit         hold_v = 0;
    logic [3:0] hold_bits;
    logic [2:0] hold_len;
    int         ar_pct = 100;
    int         force_low = 0;
    bit         br_low_seen = 0;
    bit         in_reset = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_chunk(input logic [2:0] c);
        return (c == 3'd0 || c > 3'd4) ? 4 : int'(c);
    endfunction

    // Reference: stream bits in order; cut full chunks of C, a short tail only at stream end
    function automatic void model_byte(input logic [7:0] d, input bit last,
                                       input logic [2:0] lb, input int c);
        chunk_t e;
        int n;
        n = (last && lb != 3'd0) ? int'(lb) : 8;
        for (int i = 0; i < n; i++) mq.push_back(d[7-i]);
        while (mq.size() >= c) begin
            e.bits = '0;
            for (int k = 0; k < c; k++) e.bits = {e.bits[2:0], mq.pop_front()};
            e.len  = c;
            e.last = last && (mq.size() == 0);
            exp_q.push_back(e);
        end
        if (last && mq.size() > 0) begin
            e.bits = '0;
            e.len  = mq.size();
            while (mq.size() > 0) e.bits = {e.bits[2:0], mq.pop_front()};
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        chunk_t e;
        if (!in_reset) begin
            chk("stream_done", 32'(stream_done), 32'(done_next));
            chk("bits_sent", 32'(bits_sent), 32'(model_sent[15:0]));
            if (!byte_ready) br_low_seen = 1'b1;
            if (hold_v) begin
                chk("hold_svalid", 32'(svalid), 32'd1);
                chk("hold_bits", 32'(in_bits), 32'(hold_bits));
                chk("hold_len", 32'(in_len), 32'(hold_len));
            end
            hold_v    = svalid && !aready;
            hold_bits = in_bits;
            hold_len  = in_len;
            done_next = 1'b0;
            if (svalid && aready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_chunk", 32'(in_bits), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("chunk_bits", 32'(in_bits), 32'(e.bits));
                    chk("chunk_len", 32'(in_len), 32'(e.len));
                    done_next  = e.last;
                    model_sent = model_sent + e.len;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (force_low > 0) begin
            aready    = 1'b0;
            force_low = force_low - 1;
        end else begin
            aready = ($urandom_range(0, 99) < ar_pct);
        end
    end

    task automatic do_reset();
        in_reset = 1'b1;
        reset    = 1'b0;
        #1;
        chk("rst_svalid", 32'(svalid), 32'd0);
        chk("rst_bits_sent", 32'(bits_sent), 32'd0);
        chk("rst_in_len", 32'(in_len), 32'd0);
        chk("rst_in_bits", 32'(in_bits), 32'd0);
        chk("rst_stream_done", 32'(stream_done), 32'd0);
        chk("rst_byte_ready", 32'(byte_ready), 32'd1);
        exp_q.delete();
        mq.delete();
        model_sent = 0;
        done_next  = 1'b0;
        hold_v     = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input logic [2:0] lb);
        int cnt;
        cnt            = 0;
        byte_valid     = 1'b1;
        byte_data      = d;
        byte_last      = last;
        byte_last_bits = lb;
        forever begin
            @(negedge clk);
            if (byte_ready) begin
                model_byte(d, last, lb, eff_chunk(cfg_chunk));
                break;
            end
            cnt++;
            if (cnt > 1000) begin
                chk("byte_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || done_next || svalid) && cnt < 3000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 3000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int nb;
        cfg_chunk = 3'd4; byte_valid = 1'b0; byte_data = '0;
        byte_last = 1'b0; byte_last_bits = '0; aready = 1'b0;
        do_reset();
        ar_pct = 100;

        cfg_chunk = 3'd4; send_byte(8'hB4, 1'b1, 3'd0); wait_idle();
        cfg_chunk = 3'd3; send_byte(8'hB4, 1'b1, 3'd0); wait_idle();
        cfg_chunk = 3'd4; send_byte(8'hE0, 1'b1, 3'd3); wait_idle();

        cfg_chunk = 3'd4;
        br_low_seen = 1'b0;
        send_byte(8'h12, 1'b0, 3'd0);
        force_low = 5;
        send_byte(8'h34, 1'b0, 3'd0);
        send_byte(8'h56, 1'b0, 3'd0);
        wait_idle();
        chk("byte_ready_drop", 32'(br_low_seen), 32'd1);

        cfg_chunk = 3'd1; send_byte(8'h81, 1'b0, 3'd0); wait_idle();
        chk("run_after_no_last", 32'(byte_ready), 32'd1);

        cfg_chunk = 3'd4;
        ar_pct = 0;
        send_byte(8'hAB, 1'b0, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_svalid", 32'(svalid), 32'd1);
        do_reset();
        ar_pct = 100;
        send_byte(8'hF0, 1'b1, 3'd0);
        wait_idle();

        for (int s = 0; s < 40; s++) begin
            cfg_chunk = 3'($urandom_range(0, 7));
            ar_pct    = $urandom_range(30, 100);
            nb        = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                send_byte(8'($urandom), b == nb - 1, 3'($urandom_range(0, 7)));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
